decode_exec_unit: RTL and testbench
===================================

// Module: decode_exec_unit
// PURPOSE
//  RV32I decode + branch-compare + execute slice of the single-cycle core.
//  Takes the fetched instruction, current PC and both register-file read ports.
//  Produces control signals, immediate, register addresses, branch flags and the ALU result.
//  Sits between inst_mem/Registers and data memory/writeback.
// PARAMETERS
//  XLEN   32  datapath width (only 32 supported)
// PORTS
//  clk       in   1   system clock (sticky status; optional output register)
//  rst       in   1   asynchronous reset, active-low
//  inst_i    in   32  instruction word
//  pc_i      in   32  PC of inst_i
//  rs1_data  in   32  register-file read data, port 1 (ALU operand A source)
//  rs2_data  in   32  register-file read data, port 2 (ALU operand B / store data)
//  PCSel     out  1   1 = next PC is ALUOut (taken branch, jal, jalr)
//  RegWE     out  1   register-file write enable
//  MemWE     out  1   data-memory write enable
//  WBSel     out  2   0 = mem, 1 = ALU, 2 = PC+4
//  Imm       out  32  sign-extended immediate
//  rs1,rs2,rd out 5   inst_i[19:15], [24:20], [11:7]
//  BrEq      out  1   rs1_data == rs2_data
//  BrLt      out  1   rs1_data < rs2_data (signed for funct3[1]=0, unsigned for 1)
//  ALUop_o   out  5   decoded ALU operation
//  ALUOut    out  32  ALU result
//  illegal_o out  1   sticky: an unsupported opcode/funct was decoded
// BEHAVIOUR
//  - rst low (async): all outputs 0, illegal_o cleared. Outputs stay 0 while rst low.
//  - rst high: everything except illegal_o is combinational, zero latency.
//  - Immediate forms:
//    - I: sext [31:20]
//    - S: sext {[31:25],[11:7]}
//    - B: sext {[31],[7],[30:25],[11:8],0}
//    - U: {[31:12],12'b0}
//    - J: sext {[31],[19:12],[20],[30:21],0}
//  - Operand selects: A = PC for auipc/jal/branch, else rs1_data. B = Imm for all but R-type, else rs2_data.
//  - ALUop encoding: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10.
//  - Decode by opcode:
//    - R (0110011): ops per funct3/funct7[5]; RegWE=1, WBSel=1.
//    - I-ALU (0010011): as R-type; only srai uses funct7[5]; RegWE=1, WBSel=1.
//    - lw (0000011): ADD; RegWE=1, WBSel=0.
//    - sw (0100011): ADD; MemWE=1.
//    - branch (1100011): ADD(PC+Imm). PCSel per funct3:
//      - beq BrEq, bne !BrEq
//      - blt/bltu BrLt, bge/bgeu !BrLt
//    - lui: PASSB. auipc: ADD(PC+Imm). Both RegWE=1, WBSel=1.
//    - jal: PC+Imm. jalr: (rs1+Imm) with bit0 cleared. Both PCSel=1, RegWE=1, WBSel=2.
//  - Shifts use B[4:0]. Add/sub wrap modulo 2^32. SLT/SLTU output 0/1.
//  - Any other opcode/funct: all enables 0, PCSel=0, ALUop=ADD. illegal_o set on next clk edge.
//  - rd=x0 is not special-cased here; the register file ignores writes to x0.
//  - BrEq/BrLt are computed for every instruction, not only branches.
// CONFIGURATION
//  DX_REG_OUT_EN defined: ALUOut, PCSel, RegWE, MemWE, WBSel registered on posedge clk.
//    - 1-cycle latency; all of them reset to 0.
//    - BrEq/BrLt/Imm/rs*/rd/ALUop_o stay combinational.
//  Undefined: fully combinational as above (default, single-cycle core).
// STRUCTURE
//  dx_pkg: opcode localparams, ALUop codes, WBSel codes, funct3 branch codes.
//  Sub-module dx_alu (A, B, ALUop -> result). Decoder and comparator stay inline.
// TESTING
//  1. rst=0 at t=0, released at 15 ns -> every output 0 until release; illegal_o=0.
//  2. 0x00500093 (addi x1,x0,5), rs1_data=0 -> rd=1, Imm=5, ALUOut=5, RegWE=1, WBSel=1, PCSel=0.
//  3. 0x40208133 (sub x2,x1,x2), rs1=7, rs2=9 -> ALUOut=0xFFFFFFFE, ALUop_o=1.
//  4. 0x00208463 (beq x1,x2,+8), pc=0x10, equal data -> BrEq=1, PCSel=1, ALUOut=0x18.
//     Unequal data -> PCSel=0.
//  5. 0x0020A223 (sw x2,4(x1)), rs1=0x100 -> MemWE=1, RegWE=0, ALUOut=0x104.
//  6. 0x00000000 -> enables 0; illegal_o=1 after next edge, held until rst low.

Source files
------------

// File: rtl/dx_pkg.sv
// dx_pkg: shared decode constants for the RV32I decode/execute slice.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package dx_pkg;

    // Major opcodes handled by the slice
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // ALU operation codes (values are visible on ALUop_o)
    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SLT   = 5'd3,
        ALU_SLTU  = 5'd4,
        ALU_XOR   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_OR    = 5'd8,
        ALU_AND   = 5'd9,
        ALU_PASSB = 5'd10
    } alu_op_e;

    // Writeback source select
    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU funct3 codes that need extra funct7 qualification, and word access
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Map an OP/OP-IMM funct3 (plus the funct7[5] alternate flag) to an ALU op
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dx_alu.sv
// dx_alu: 32-bit RV32I integer ALU (add/sub/shifts/compares/logic/pass-B).
// Latency: zero, purely combinational.
// Backpressure: none.
module dx_alu
    import dx_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] res_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Select the result for the requested operation; add/sub wrap naturally
    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:   res_o = a_i + b_i;
            ALU_SUB:   res_o = a_i - b_i;
            ALU_SLL:   res_o = a_i << shamt;
            ALU_SLT:   res_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  res_o = {31'b0, (a_i < b_i)};
            ALU_XOR:   res_o = a_i ^ b_i;
            ALU_SRL:   res_o = a_i >> shamt;
            ALU_SRA:   res_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:    res_o = a_i | b_i;
            ALU_AND:   res_o = a_i & b_i;
            ALU_PASSB: res_o = b_i;
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_exec_unit.sv
// decode_exec_unit: RV32I decode + branch compare + ALU execute slice; DX_REG_OUT_EN registers ALUOut/PCSel/RegWE/MemWE/WBSel.
// Latency: zero by default (1 cycle for the registered group with DX_REG_OUT_EN); illegal_o is sticky, set on the clk edge after decode.
// Backpressure: none; one instruction per cycle, all outputs forced to 0 while rst is low.
module decode_exec_unit
    import dx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            PCSel,
    output logic            RegWE,
    output logic            MemWE,
    output logic [1:0]      WBSel,
    output logic [XLEN-1:0] Imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            BrEq,
    output logic            BrLt,
    output logic [4:0]      ALUop_o,
    output logic [XLEN-1:0] ALUOut,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm_sel;
    logic        a_is_pc, b_is_imm, is_jalr, dec_illegal;
    alu_op_e     alu_op;
    logic        br_eq, br_lt;
    logic [31:0] alu_a, alu_b, alu_res;

    logic        pc_sel_d, reg_we_d, mem_we_d;
    logic [1:0]  wb_sel_d;
    logic [31:0] alu_out_d;
    logic        illegal_d, illegal_q;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Branch comparator runs for every instruction; funct3[1] picks unsigned compare
    always_comb begin
        br_eq = (rs1_data == rs2_data);
        br_lt = funct3[1] ? (rs1_data < rs2_data)
                          : ($signed(rs1_data) < $signed(rs2_data));
    end

    // Main decoder: control enables, immediate format, operand selects, ALU op
    always_comb begin
        imm_sel     = '0;
        a_is_pc     = 1'b0;
        b_is_imm    = 1'b1;
        is_jalr     = 1'b0;
        dec_illegal = 1'b0;
        alu_op      = ALU_ADD;
        reg_we_d    = 1'b0;
        mem_we_d    = 1'b0;
        wb_sel_d    = WB_MEM;
        pc_sel_d    = 1'b0;
        case (opcode)
            OPC_R: begin
                b_is_imm = 1'b0;
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))) begin
                    alu_op   = arith_op(funct3, funct7[5]);
                    reg_we_d = 1'b1;
                    wb_sel_d = WB_ALU;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_IALU: begin
                imm_sel = imm_i;
                // Only the shift-immediates constrain the upper immediate bits
                if ((funct3 == F3_SLL && funct7 != F7_BASE) ||
                    (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT)) begin
                    dec_illegal = 1'b1;
                end else begin
                    alu_op   = arith_op(funct3, (funct3 == F3_SR) && funct7[5]);
                    reg_we_d = 1'b1;
                    wb_sel_d = WB_ALU;
                end
            end
            OPC_LOAD: begin
                imm_sel = imm_i;
                if (funct3 == F3_WORD) begin
                    reg_we_d = 1'b1;
                    wb_sel_d = WB_MEM;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                imm_sel = imm_s;
                if (funct3 == F3_WORD) begin
                    mem_we_d = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                imm_sel = imm_b;
                a_is_pc = 1'b1;
                case (funct3)
                    F3_BEQ:           pc_sel_d = br_eq;
                    F3_BNE:           pc_sel_d = !br_eq;
                    F3_BLT, F3_BLTU:  pc_sel_d = br_lt;
                    F3_BGE, F3_BGEU:  pc_sel_d = !br_lt;
                    default:          dec_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                imm_sel  = imm_u;
                alu_op   = ALU_PASSB;
                reg_we_d = 1'b1;
                wb_sel_d = WB_ALU;
            end
            OPC_AUIPC: begin
                imm_sel  = imm_u;
                a_is_pc  = 1'b1;
                reg_we_d = 1'b1;
                wb_sel_d = WB_ALU;
            end
            OPC_JAL: begin
                imm_sel  = imm_j;
                a_is_pc  = 1'b1;
                pc_sel_d = 1'b1;
                reg_we_d = 1'b1;
                wb_sel_d = WB_PC4;
            end
            OPC_JALR: begin
                imm_sel = imm_i;
                if (funct3 == F3_ADD) begin
                    is_jalr  = 1'b1;
                    pc_sel_d = 1'b1;
                    reg_we_d = 1'b1;
                    wb_sel_d = WB_PC4;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        // An illegal instruction must never redirect the PC or write state
        if (dec_illegal) begin
            pc_sel_d = 1'b0;
            reg_we_d = 1'b0;
            mem_we_d = 1'b0;
            wb_sel_d = WB_MEM;
            alu_op   = ALU_ADD;
        end
    end

    // Operand muxes and jalr target alignment
    always_comb begin
        alu_a     = a_is_pc ? pc_i : rs1_data;
        alu_b     = b_is_imm ? imm_sel : rs2_data;
        alu_out_d = is_jalr ? {alu_res[31:1], 1'b0} : alu_res;
    end

    dx_alu u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .op_i  (alu_op),
        .res_o (alu_res)
    );

    // Sticky illegal flag accumulates every illegal decode seen at a clock edge
    always_comb begin
        illegal_d = illegal_q | dec_illegal;
    end

    // Sticky illegal flag register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;

    // Outputs that are always combinational, held at 0 during reset
    assign Imm     = rst ? imm_sel       : '0;
    assign rs1     = rst ? inst_i[19:15] : '0;
    assign rs2     = rst ? inst_i[24:20] : '0;
    assign rd      = rst ? inst_i[11:7]  : '0;
    assign BrEq    = rst & br_eq;
    assign BrLt    = rst & br_lt;
    assign ALUop_o = rst ? alu_op        : ALU_ADD;

`ifdef DX_REG_OUT_EN
    logic        pc_sel_q, reg_we_q, mem_we_q;
    logic [1:0]  wb_sel_q;
    logic [31:0] alu_out_q;

    // Output register stage for the execute result and control enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_sel_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            wb_sel_q  <= WB_MEM;
            alu_out_q <= '0;
        end else begin
            pc_sel_q  <= pc_sel_d;
            reg_we_q  <= reg_we_d;
            mem_we_q  <= mem_we_d;
            wb_sel_q  <= wb_sel_d;
            alu_out_q <= alu_out_d;
        end
    end

    assign PCSel  = pc_sel_q;
    assign RegWE  = reg_we_q;
    assign MemWE  = mem_we_q;
    assign WBSel  = wb_sel_q;
    assign ALUOut = alu_out_q;
`else
    assign PCSel  = rst & pc_sel_d;
    assign RegWE  = rst & reg_we_d;
    assign MemWE  = rst & mem_we_d;
    assign WBSel  = rst ? wb_sel_d  : WB_MEM;
    assign ALUOut = rst ? alu_out_d : '0;
`endif

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: directed + randomized self-checking bench against an instruction-level reference model.
// Latency: checks combinational outputs 2 ns after each negedge drive; sticky flag checked after edges.
// Backpressure: n/a.
module tb_decode_exec_unit;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0, pc_i = '0, rs1_data = '0, rs2_data = '0;

    logic        PCSel, RegWE, MemWE, BrEq, BrLt, illegal_o;
    logic [1:0]  WBSel;
    logic [31:0] Imm, ALUOut;
    logic [4:0]  rs1, rs2, rd, ALUop_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        pcsel;
        logic        regwe;
        logic        memwe;
        logic [1:0]  wbsel;
        logic [31:0] imm;
        logic [4:0]  aluop;
        logic [31:0] aluout;
        logic        breq;
        logic        brlt;
        logic        illegal;
    } exp_t;

    exp_t e_now;
    logic sticky = 1'b0;
    logic [6:0] opc [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    decode_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .inst_i    (inst_i),
        .pc_i      (pc_i),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .PCSel     (PCSel),
        .RegWE     (RegWE),
        .MemWE     (MemWE),
        .WBSel     (WBSel),
        .Imm       (Imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .BrEq      (BrEq),
        .BrLt      (BrLt),
        .ALUop_o   (ALUop_o),
        .ALUOut    (ALUOut),
        .illegal_o (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h inst=%h", tag, got, exp, inst_i);
        end
    endtask

    // Reference ALU: plain arithmetic per operation code
    function automatic logic [31:0] ref_alu(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
        case (code)
            5'd0:    return x + y;
            5'd1:    return x - y;
            5'd2:    return x << y[4:0];
            5'd3:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd4:    return (x < y) ? 32'd1 : 32'd0;
            5'd5:    return x ^ y;
            5'd6:    return x >> y[4:0];
            5'd7:    return $unsigned($signed(x) >>> y[4:0]);
            5'd8:    return x | y;
            5'd9:    return x & y;
            default: return y;
        endcase
    endfunction

    function automatic logic [4:0] ref_op(input logic [2:0] f3, input logic alt);
        logic [4:0] tbl [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        if (alt && f3 == 3'd0) return 5'd1;
        if (alt && f3 == 3'd5) return 5'd7;
        return tbl[f3];
    endfunction

    // Instruction-level reference: what the slice should produce for one instruction
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] ii, is, ib, iu, ij;
        f3 = w[14:12];
        f7 = w[31:25];
        ii = {{20{w[31]}}, w[31:20]};
        is = {{20{w[31]}}, w[31:25], w[11:7]};
        ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        iu = {w[31:12], 12'b0};
        ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e = '0;
        e.breq = (a == b);
        e.brlt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        case (w[6:0])
            7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                       e.aluop = ref_op(f3, f7[5]);
                       e.aluout = ref_alu(e.aluop, a, b);
                       e.regwe = 1'b1; e.wbsel = 2'd1;
                   end else e.illegal = 1'b1;
            7'h13: begin
                       e.imm = ii;
                       if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
                           e.illegal = 1'b1;
                       else begin
                           e.aluop = ref_op(f3, f3 == 3'd5 && f7[5]);
                           e.aluout = ref_alu(e.aluop, a, ii);
                           e.regwe = 1'b1; e.wbsel = 2'd1;
                       end
                   end
            7'h03: begin
                       e.imm = ii;
                       if (f3 == 3'd2) begin e.aluout = a + ii; e.regwe = 1'b1; end
                       else e.illegal = 1'b1;
                   end
            7'h23: begin
                       e.imm = is;
                       if (f3 == 3'd2) begin e.aluout = a + is; e.memwe = 1'b1; end
                       else e.illegal = 1'b1;
                   end
            7'h63: begin
                       e.imm = ib;
                       if (f3 == 3'd2 || f3 == 3'd3) e.illegal = 1'b1;
                       else begin
                           e.aluout = pc + ib;
                           e.pcsel = f3[2] ? (e.brlt ^ f3[0]) : (e.breq ^ f3[0]);
                       end
                   end
            7'h37: begin e.imm = iu; e.aluop = 5'd10; e.aluout = iu; e.regwe = 1'b1; e.wbsel = 2'd1; end
            7'h17: begin e.imm = iu; e.aluout = pc + iu; e.regwe = 1'b1; e.wbsel = 2'd1; end
            7'h6F: begin e.imm = ij; e.aluout = pc + ij; e.pcsel = 1'b1; e.regwe = 1'b1; e.wbsel = 2'd2; end
            7'h67: begin
                       e.imm = ii;
                       if (f3 == 3'd0) begin
                           e.aluout = (a + ii) & 32'hFFFF_FFFE;
                           e.pcsel = 1'b1; e.regwe = 1'b1; e.wbsel = 2'd2;
                       end else e.illegal = 1'b1;
                   end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    always_comb e_now = model(inst_i, pc_i, rs1_data, rs2_data);

    // Expected sticky flag: set by any illegal instruction present at a rising edge
    always @(posedge clk or negedge rst) begin
        if (!rst) sticky <= 1'b0;
        else if (e_now.illegal) sticky <= 1'b1;
    end

    task automatic compare_all();
        if (!rst) begin
            check("rst_pcsel",  32'(PCSel),     32'd0);
            check("rst_regwe",  32'(RegWE),     32'd0);
            check("rst_memwe",  32'(MemWE),     32'd0);
            check("rst_wbsel",  32'(WBSel),     32'd0);
            check("rst_imm",    Imm,            32'd0);
            check("rst_rs1",    32'(rs1),       32'd0);
            check("rst_rs2",    32'(rs2),       32'd0);
            check("rst_rd",     32'(rd),        32'd0);
            check("rst_breq",   32'(BrEq),      32'd0);
            check("rst_brlt",   32'(BrLt),      32'd0);
            check("rst_aluop",  32'(ALUop_o),   32'd0);
            check("rst_aluout", ALUOut,         32'd0);
            check("rst_illegal",32'(illegal_o), 32'd0);
        end else begin
            check("pcsel",   32'(PCSel),     32'(e_now.pcsel));
            check("regwe",   32'(RegWE),     32'(e_now.regwe));
            check("memwe",   32'(MemWE),     32'(e_now.memwe));
            check("wbsel",   32'(WBSel),     32'(e_now.wbsel));
            check("rs1",     32'(rs1),       32'(inst_i[19:15]));
            check("rs2",     32'(rs2),       32'(inst_i[24:20]));
            check("rd",      32'(rd),        32'(inst_i[11:7]));
            check("breq",    32'(BrEq),      32'(e_now.breq));
            check("brlt",    32'(BrLt),      32'(e_now.brlt));
            check("aluop",   32'(ALUop_o),   32'(e_now.aluop));
            check("illegal", 32'(illegal_o), 32'(sticky));
            if (!e_now.illegal) begin
                check("imm",    Imm,    e_now.imm);
                check("aluout", ALUOut, e_now.aluout);
            end
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        inst_i = w; pc_i = p; rs1_data = a; rs2_data = b;
        #2;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        inst_i = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        #2;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held from t=0 with a legal instruction present; outputs must stay 0
        inst_i = 32'h0050_0093; rs1_data = 32'd3;
        #2  compare_all();
        #10 compare_all();
        #3  rst = 1'b1;

        // addi x1,x0,5
        drive(32'h0050_0093, 32'h0, 32'd0, 32'd0);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_imm", Imm, 32'd5);
        check("addi_out", ALUOut, 32'd5);
        check("addi_regwe", 32'(RegWE), 32'd1);
        check("addi_wbsel", 32'(WBSel), 32'd1);
        check("addi_pcsel", 32'(PCSel), 32'd0);

        // sub x2,x1,x2
        drive(32'h4020_8133, 32'h4, 32'd7, 32'd9);
        check("sub_out", ALUOut, 32'hFFFF_FFFE);
        check("sub_op", 32'(ALUop_o), 32'd1);

        // beq x1,x2,+8 taken then not taken
        drive(32'h0020_8463, 32'h10, 32'h55, 32'h55);
        check("beq_eq", 32'(BrEq), 32'd1);
        check("beq_pcsel", 32'(PCSel), 32'd1);
        check("beq_out", ALUOut, 32'h18);
        drive(32'h0020_8463, 32'h10, 32'h55, 32'h56);
        check("beq_ne_pcsel", 32'(PCSel), 32'd0);

        // sw x2,4(x1)
        drive(32'h0020_A223, 32'h20, 32'h100, 32'hABCD);
        check("sw_memwe", 32'(MemWE), 32'd1);
        check("sw_regwe", 32'(RegWE), 32'd0);
        check("sw_out", ALUOut, 32'h104);

        // all-zero word is illegal: enables low, sticky flag after the edge
        drive(32'h0000_0000, 32'h24, 32'h1, 32'h2);
        check("ill_pre", 32'(illegal_o), 32'd0);
        @(posedge clk);
        #1 check("ill_set", 32'(illegal_o), 32'd1);
        drive(32'h0050_0093, 32'h28, 32'd0, 32'd0);
        check("ill_hold", 32'(illegal_o), 32'd1);
        do_reset();

        // Randomized instructions, mostly well-formed, with periodic resets
        for (int it = 0; it < 400; it++) begin
            logic [31:0] w, a, b, p;
            int k;
            if (it % 40 == 39) do_reset();
            k = $urandom_range(0, 9);
            w = $urandom;
            if (k < 9) begin
                w[6:0] = opc[k];
                if ($urandom_range(0, 3) != 0) begin
                    case (w[6:0])
                        7'h33: w[31:25] = (($urandom_range(0, 1) == 1) &&
                                           (w[14:12] == 3'd0 || w[14:12] == 3'd5)) ? 7'h20 : 7'h00;
                        7'h13: if (w[14:12] == 3'd1) w[31:25] = 7'h00;
                               else if (w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                        7'h03, 7'h23: w[14:12] = 3'd2;
                        7'h63: if (w[14:13] == 2'b01) w[14] = 1'b1;
                        7'h67: w[14:12] = 3'd0;
                        default: ;
                    endcase
                end
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            p = $urandom & 32'hFFFF_FFFC;
            drive(w, p, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
